// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dsp_pkg
// Brief   : Shared DSP result-path constants, width helpers and entry type.
// Revision: 1.0 - initial release
// ============================================================================
package dsp_pkg;

  localparam int MAX_DSP_LATENCY = 3;
  localparam int DSP_OUT_W       = 16;

  function automatic int dsp_in_w(input int n, input int m);
    return n + m;
  endfunction

  function automatic int sat_max(input int w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 <<< (w - 1));
  endfunction

  typedef struct packed {
    logic                        sat;
    logic signed [DSP_OUT_W-1:0] data;
  } drain_entry_t;

endpackage
`default_nettype wire

// File: rtl/dsp_result_drain_if.sv
`default_nettype none
// ============================================================================
// Module  : dsp_result_drain_if
// Brief   : DSP result input and valid/ready drain bundle with status flags.
// Revision: 1.0 - initial release
// ============================================================================
interface dsp_result_drain_if
  import dsp_pkg::*;
#(
  parameter int N     = 9,
  parameter int M     = 9,
  parameter int OUT_W = DSP_OUT_W,
  parameter int DEPTH = 8
);
  localparam int IN_W = dsp_in_w(N, M);
  localparam int CW   = $clog2(DEPTH) + 1;

  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic [4:0]              in_shift;
  logic                    m_valid;
  logic                    m_ready;
  logic signed [OUT_W-1:0] m_data;
  logic                    m_sat;
  logic [CW-1:0]           count;
  logic                    almost_full;
  logic                    overflow;

  modport master (
    output in_valid, in_data, in_shift, m_ready,
    input  m_valid, m_data, m_sat, count, almost_full, overflow
  );

  modport slave (
    input  in_valid, in_data, in_shift, m_ready,
    output m_valid, m_data, m_sat, count, almost_full, overflow
  );

endinterface
`default_nettype wire

// File: rtl/drain_fifo.sv
`default_nettype none
// ============================================================================
// Module  : drain_fifo
// Brief   : Synchronous FIFO; head output holds the last popped word when empty.
// Revision: 1.0 - initial release
// ============================================================================
module drain_fifo #(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_wr_en,
  input  wire logic [WIDTH-1:0] i_wr_data,
  input  wire logic             i_rd_en,
  output logic      [WIDTH-1:0] o_rd_data,
  output logic                  o_valid,
  output logic      [CW-1:0]    o_count,
  output logic      [CW-1:0]    o_count_next,
  output logic                  o_drop
);

  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_last;
  logic [CW-1:0]    w_count_next;
  logic             w_wr;
  logic             w_rd;

  // A pop frees a slot in the same edge, so a full FIFO still takes a write.
  assign w_rd   = i_rd_en && (r_count != '0);
  assign w_wr   = i_wr_en && ((r_count != c_FULL) || w_rd);
  assign o_drop = i_wr_en && !w_wr;

  always_comb begin
    w_count_next = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_next;
    end
  end

  assign o_valid      = (r_count != '0);
  assign o_rd_data    = o_valid ? r_mem[r_rd_ptr] : r_last;
  assign o_count      = r_count;
  assign o_count_next = w_count_next;

endmodule
`default_nettype wire

// File: rtl/dsp_result_drain.sv
`default_nettype none
// ============================================================================
// Module  : dsp_result_drain
// Brief   : Captures DSP results, rounds/shifts/saturates them, queues them.
// Revision: 1.0 - initial release
// ============================================================================
module dsp_result_drain
  import dsp_pkg::*;
#(
  parameter int N        = 9,
  parameter int M        = 9,
  parameter int OUT_W    = DSP_OUT_W,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input wire logic           clk,
  input wire logic           rst_n,
  dsp_result_drain_if.slave  bus
);

  localparam int IN_W       = dsp_in_w(N, M);
  localparam int CW         = $clog2(DEPTH) + 1;
  localparam int c_SH_MAX_I = (IN_W - 1 > 31) ? 31 : IN_W - 1;

  localparam logic [4:0]              c_SH_MAX   = 5'(c_SH_MAX_I);
  localparam logic signed [IN_W:0]    c_ONE      = (IN_W + 1)'(1);
  localparam logic signed [IN_W:0]    c_SAT_MAX  = (IN_W + 1)'(sat_max(OUT_W));
  localparam logic signed [IN_W:0]    c_SAT_MIN  = (IN_W + 1)'(sat_min(OUT_W));
  localparam logic signed [OUT_W-1:0] c_OUT_MAX  = OUT_W'(sat_max(OUT_W));
  localparam logic signed [OUT_W-1:0] c_OUT_MIN  = OUT_W'(sat_min(OUT_W));
  localparam logic [CW-1:0]           c_AF_LEVEL = CW'(AF_LEVEL);

  typedef struct packed {
    logic                    sat;
    logic signed [OUT_W-1:0] data;
  } entry_t;

  logic                   r_s1_v;
  logic signed [IN_W-1:0] r_s1_data;
  logic [4:0]             r_s1_sh;
  logic                   r_af;
  logic                   r_ovf;

  logic [4:0]             w_sh_clamp;
  logic signed [IN_W:0]   w_wide;
  logic signed [IN_W:0]   w_bias;
  logic signed [IN_W:0]   w_sum;
  logic signed [IN_W:0]   w_shifted;
  entry_t                 w_entry;
  entry_t                 w_head;
  logic [CW-1:0]          w_count_next;
  logic                   w_drop;

  assign w_sh_clamp = (bus.in_shift > c_SH_MAX) ? c_SH_MAX : bus.in_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
      r_s1_sh   <= '0;
    end else begin
      r_s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_data <= bus.in_data;
        r_s1_sh   <= w_sh_clamp;
      end
    end
  end

  // One guard bit keeps value + half-LSB from wrapping at the positive limit.
  always_comb begin
    w_wide = {r_s1_data[IN_W-1], r_s1_data};
    w_bias = '0;
    if (r_s1_sh != 5'd0) w_bias = c_ONE << (r_s1_sh - 5'd1);
    w_sum     = w_wide + w_bias;
    w_shifted = w_sum >>> r_s1_sh;
    w_entry.sat  = 1'b0;
    w_entry.data = w_shifted[OUT_W-1:0];
    if (w_shifted > c_SAT_MAX) begin
      w_entry.sat  = 1'b1;
      w_entry.data = c_OUT_MAX;
    end else if (w_shifted < c_SAT_MIN) begin
      w_entry.sat  = 1'b1;
      w_entry.data = c_OUT_MIN;
    end
  end

  drain_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wr_en      (r_s1_v),
    .i_wr_data    (w_entry),
    .i_rd_en      (bus.m_ready),
    .o_rd_data    (w_head),
    .o_valid      (bus.m_valid),
    .o_count      (bus.count),
    .o_count_next (w_count_next),
    .o_drop       (w_drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_af  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_af  <= (w_count_next >= c_AF_LEVEL);
      r_ovf <= r_ovf | w_drop;
    end
  end

  assign bus.m_data      = w_head.data;
  assign bus.m_sat       = w_head.sat;
  assign bus.almost_full = r_af;
  assign bus.overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dsp_result_drain.sv
`default_nettype none
// ============================================================================
// Module  : tb_dsp_result_drain
// Brief   : Directed and random stimulus against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dsp_result_drain;

  localparam int DEPTH = 8;
  localparam int AF    = 6;

  typedef struct {
    int data;
    bit sat;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsp_result_drain_if #(.N(9), .M(9), .OUT_W(16), .DEPTH(DEPTH)) bus ();

  dsp_result_drain #(
    .N(9), .M(9), .OUT_W(16), .DEPTH(DEPTH), .AF_LEVEL(AF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_pass = 0;
  int   n_chk  = 0;
  ent_t q[$];
  ent_t last;
  ent_t pend_e;
  bit   pend_v;
  bit   ovf;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Round half up via floor division, then clip to the signed 16-bit range.
  function automatic ent_t ref_result(input int d, input int sh);
    ent_t   r;
    int     s;
    longint num, den, quo;
    s = (sh > 17) ? 17 : sh;
    if (s == 0) quo = d;
    else begin
      den = longint'(1) << s;
      num = longint'(d) + den / 2;
      quo = num / den;
      if ((num % den) != 0 && num < 0) quo = quo - 1;
    end
    if (quo > 32767)       r = '{32767, 1'b1};
    else if (quo < -32768) r = '{-32768, 1'b1};
    else                   r = '{int'(quo), 1'b0};
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    last   = '{0, 1'b0};
    pend_v = 1'b0;
    ovf    = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".m_valid"},     bus.m_valid, q.size() > 0);
    check({tag, ".count"},       bus.count, q.size());
    check({tag, ".almost_full"}, bus.almost_full, q.size() >= AF);
    check({tag, ".overflow"},    bus.overflow, ovf);
    if (q.size() > 0) begin
      check({tag, ".m_data"}, bus.m_data, q[0].data);
      check({tag, ".m_sat"},  bus.m_sat, q[0].sat);
    end else begin
      check({tag, ".m_data_hold"}, bus.m_data, last.data);
    end
  endtask

  task automatic cycle(input string tag, input logic v, input logic signed [17:0] d,
                       input logic [4:0] sh, input logic rdy);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_shift = sh;
    bus.m_ready  = rdy;
    @(posedge clk);
    if (rdy && q.size() > 0) last = q.pop_front();
    if (pend_v) begin
      if (q.size() < DEPTH) q.push_back(pend_e);
      else ovf = 1'b1;
    end
    pend_v = v;
    if (v) pend_e = ref_result(int'(d), int'(sh));
    #1;
    compare_all(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".m_valid"},     bus.m_valid, 0);
    check({tag, ".m_data"},      bus.m_data, 0);
    check({tag, ".m_sat"},       bus.m_sat, 0);
    check({tag, ".count"},       bus.count, 0);
    check({tag, ".almost_full"}, bus.almost_full, 0);
    check({tag, ".overflow"},    bus.overflow, 0);
  endtask

  typedef struct {
    int d;
    int sh;
    int exp_d;
    bit exp_s;
  } vec_t;

  vec_t vecs[8] = '{
    '{131071, 0, 32767, 1'b1}, '{-131072, 0, -32768, 1'b1},
    '{-32768, 0, -32768, 1'b0}, '{7, 2, 2, 1'b0},
    '{-7, 2, -2, 1'b0}, '{6, 2, 2, 1'b0},
    '{5, 0, 5, 1'b0}, '{-1, 31, 0, 1'b0}
  };

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_shift = '0;
    bus.m_ready  = 1'b0;
    model_reset();
    #1;
    check_zero("por");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle("idle", 1'b0, 18'sd0, 5'd0, 1'b1);

    // Basic latency
    cycle("lat_k", 1'b1, 18'sd1000, 5'd0, 1'b1);
    check("lat_k.no_bypass", bus.m_valid, 0);
    cycle("lat_k1", 1'b0, 18'sd0, 5'd0, 1'b1);
    check("lat_k1.m_data", bus.m_data, 1000);
    check("lat_k1.m_valid", bus.m_valid, 1);
    cycle("lat_k2", 1'b0, 18'sd0, 5'd0, 1'b1);
    check("lat_k2.count", bus.count, 0);

    // Rounding and saturation vectors, with a stall cycle to test holding
    foreach (vecs[i]) begin
      cycle("vec_in", 1'b1, 18'(vecs[i].d), 5'(vecs[i].sh), 1'b0);
      cycle("vec_wr", 1'b0, 18'sd0, 5'd0, 1'b0);
      cycle("vec_hold", 1'b0, 18'sd0, 5'd0, 1'b0);
      check($sformatf("vec%0d.m_data", i), bus.m_data, vecs[i].exp_d);
      check($sformatf("vec%0d.m_sat", i), bus.m_sat, vecs[i].exp_s);
      cycle("vec_pop", 1'b0, 18'sd0, 5'd0, 1'b1);
    end

    // Overflow: nine writes into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) cycle("ovf_in", 1'b1, 18'(i), 5'd0, 1'b0);
    cycle("ovf_last", 1'b0, 18'sd0, 5'd0, 1'b0);
    check("ovf.count", bus.count, 8);
    check("ovf.flag", bus.overflow, 1);
    check("ovf.af", bus.almost_full, 1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("ovf_drain%0d", i), bus.m_data, i);
      cycle("ovf_drain", 1'b0, 18'sd0, 5'd0, 1'b1);
    end
    check("ovf.empty", bus.m_valid, 0);

    // Mid-stream asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) cycle("rst_fill", 1'b1, 18'(100 + i), 5'd0, 1'b0);
    cycle("rst_fill2", 1'b0, 18'sd0, 5'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_rst", 1'b0, 18'sd0, 5'd0, 1'b1);

    // Full FIFO with simultaneous push and pop
    for (int i = 1; i <= 8; i++) cycle("fp_fill", 1'b1, 18'(i), 5'd0, 1'b0);
    cycle("fp_42", 1'b1, 18'sd42, 5'd0, 1'b0);
    check("fp.full", bus.count, 8);
    cycle("fp_pp", 1'b0, 18'sd0, 5'd0, 1'b1);
    check("fp.count", bus.count, 8);
    check("fp.ovf", bus.overflow, 0);
    for (int i = 0; i < 7; i++) cycle("fp_drain", 1'b0, 18'sd0, 5'd0, 1'b1);
    check("fp.last42", bus.m_data, 42);
    cycle("fp_end", 1'b0, 18'sd0, 5'd0, 1'b1);

    // Random traffic: congested phase then drain-heavy phase
    for (int i = 0; i < 400; i++) begin
      logic signed [17:0] rd;
      logic               rv;
      logic               rr;
      rd = 18'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      rr = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cycle("rand", rv, rd, 5'($urandom_range(0, 31)), rr);
    end
    for (int i = 0; i < 12; i++) cycle("rand_drain", 1'b0, 18'sd0, 5'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
